// File: rtl/vec_pkg.sv
// Shared encodings, FSM states and default geometry for the vector register file.
package vec_pkg;

    localparam int NUM_REGS_DEF = 4;
    localparam int LANES_DEF    = 16;
    localparam int LANE_W_DEF   = 32;
    localparam int LPC_DEF      = 4;

    localparam int AW    = (NUM_REGS_DEF > 1) ? $clog2(NUM_REGS_DEF) : 1;
    localparam int VW    = LANES_DEF * LANE_W_DEF;
    localparam int STEPS = LANES_DEF / LPC_DEF;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/vec_regfile_seq_if.sv
// Command/response bus between the vector front-end (master) and the register file (slave).
interface vec_regfile_seq_if #(
    parameter int AW = 2,
    parameter int VW = 512
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [VW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [VW-1:0] rsp_data;
    logic          done;
    logic          err;
    logic          busy;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, done, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, done, err, busy
    );
endinterface

// File: rtl/vec_lane_alu.sv
// One unsigned lane: ADD yields sum plus carry lane, MUL yields the full double-width product.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [2:0]        op,
    output logic [LANE_W-1:0] lo,
    output logic [LANE_W-1:0] hi
);
    logic [2*LANE_W-1:0] prod;
    logic [LANE_W:0]     sum;

    always_comb begin
        prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
        sum  = {1'b0, a} + {1'b0, b};
        if (op == OP_MUL) begin
            lo = prod[LANE_W-1:0];
            hi = prod[2*LANE_W-1:LANE_W];
        end else begin
            lo = sum[LANE_W-1:0];
            hi = {{(LANE_W-1){1'b0}}, sum[LANE_W]};
        end
    end
endmodule

// File: rtl/vec_regfile_seq.sv
// Vector register file with a sequenced lane-wise ADD/MUL unit; results land in rd (lo) and rd+1 (hi).
module vec_regfile_seq
    import vec_pkg::*;
#(
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int LANES         = LANES_DEF,
    parameter int LANE_W        = LANE_W_DEF,
    parameter int LANES_PER_CYC = LPC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    vec_regfile_seq_if.slave bus
);
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int VEC_W   = LANES * LANE_W;
    localparam int N_STEPS = LANES / LANES_PER_CYC;
    localparam int SLICE_W = LANES_PER_CYC * LANE_W;
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    state_t              state, state_next;
    logic [VEC_W-1:0]    regs [NUM_REGS];
    logic [VEC_W-1:0]    op_a, op_b, lo_buf, hi_buf, lo_next, hi_next;
    logic [SLICE_W-1:0]  slice_a, slice_b, slice_lo, slice_hi;
    logic [2:0]          exec_op;
    logic [ADDR_W-1:0]   exec_rd, hi_rd;
    logic [STEP_W-1:0]   step;
    logic                accept;
    logic                rsp_valid_q, done_q, err_q;
    logic [VEC_W-1:0]    rsp_data_q;

    assign bus.cmd_ready = (state == IDLE) && rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign hi_rd         = exec_rd + ADDR_W'(1);

    for (genvar g = 0; g < LANES_PER_CYC; g++) begin : g_alu
        vec_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .a  (slice_a[g*LANE_W +: LANE_W]),
            .b  (slice_b[g*LANE_W +: LANE_W]),
            .op (exec_op),
            .lo (slice_lo[g*LANE_W +: LANE_W]),
            .hi (slice_hi[g*LANE_W +: LANE_W])
        );
    end

    // The current step's slice is merged into the buffers so the final step can commit directly.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        lo_next = lo_buf;
        hi_next = hi_buf;
        for (int s = 0; s < N_STEPS; s++) begin
            if (step == STEP_W'(s)) begin
                slice_a = op_a[s*SLICE_W +: SLICE_W];
                slice_b = op_b[s*SLICE_W +: SLICE_W];
                lo_next[s*SLICE_W +: SLICE_W] = slice_lo;
                hi_next[s*SLICE_W +: SLICE_W] = slice_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && bus.cmd_op == OP_READ) state_next = RESP;
                else if (accept && (bus.cmd_op == OP_ADD || bus.cmd_op == OP_MUL)) state_next = EXEC;
            end
            EXEC:    if (step == LAST_STEP) state_next = IDLE;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            op_a        <= '0;
            op_b        <= '0;
            lo_buf      <= '0;
            hi_buf      <= '0;
            exec_op     <= '0;
            exec_rd     <= '0;
            step        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd_op)
                            OP_WRITE: begin
                                regs[bus.cmd_rd] <= bus.cmd_wdata;
                                done_q           <= 1'b1;
                            end
                            OP_READ: begin
                                rsp_data_q  <= regs[bus.cmd_rs1];
                                rsp_valid_q <= 1'b1;
                            end
                            OP_ADD, OP_MUL: begin
                                op_a    <= regs[bus.cmd_rs1];
                                op_b    <= regs[bus.cmd_rs2];
                                exec_op <= bus.cmd_op;
                                exec_rd <= bus.cmd_rd;
                                step    <= '0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                EXEC: begin
                    lo_buf <= lo_next;
                    hi_buf <= hi_next;
                    step   <= step + STEP_W'(1);
                    if (step == LAST_STEP) begin
                        regs[exec_rd] <= lo_next;
                        regs[hi_rd]   <= hi_next;
                        done_q        <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/vec_regfile_seq.md
Name: vec_regfile_seq

Overview:
Parametrised vector register file with an integrated, sequenced lane-wise execution unit. It has a valid/ready command port for write, read and vector add/multiply, and a valid/ready read-response port. Vector ops are executed LANES_PER_CYC lanes per cycle over several cycles. Each result is written as a low/high pair to registers rd and rd+1. It sits between the vector instruction front-end and the processor datapath.

Parameters:
NUM_REGS, 4, number of vector registers (power of 2, >=2)
LANES, 16, lanes per vector
LANE_W, 32, bits per lane; VW = LANES*LANE_W
LANES_PER_CYC, 4, lanes computed per EXEC cycle (divides LANES); STEPS = LANES/LANES_PER_CYC

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  3  0 WRITE, 1 READ, 2 ADD, 3 MUL, 4-7 reserved
cmd_rd  in  AW  destination register; AW = clog2(NUM_REGS)
cmd_rs1  in  AW  source 1 / read address
cmd_rs2  in  AW  source 2
cmd_wdata  in  VW  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  read data consumed
rsp_data  out  VW  read data
done  out  1  one-cycle pulse when any op completes
err  out  1  one-cycle pulse on a reserved op
busy  out  1  high when the block is not in IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE) && rst.
- Reset (rst=0 at a clk edge): all registers cleared to 0, state IDLE, rsp_valid/done/err/busy = 0, rsp_data = 0, step counter = 0. Reset mid-EXEC aborts the op: no register write and no done pulse.
- WRITE: regs[rd] <= wdata on the accept edge. State stays IDLE. done pulses the next cycle. Back-to-back accepts are allowed every cycle.
- READ: on the accept edge, rsp_data <= regs[rs1], rsp_valid <= 1, and the state goes to RESP (1-cycle latency). rsp_data and rsp_valid are held stable until rsp_valid && rsp_ready. On that edge rsp_valid <= 0, done pulses, and the state returns to IDLE.
- ADD/MUL:
  - On the accept edge, snapshot regs[rs1] and regs[rs2] into operand buffers, clear step = 0, and enter EXEC. Because operands are snapshotted, rd/rd+1 aliasing rs1/rs2 is safe.
  - Each EXEC cycle computes lanes [step*LPC, step*LPC+LPC-1] into lo/hi result buffers, then step++.
  - ADD per lane: lo = (a+b) mod 2^LANE_W; hi = carry-out zero-extended to LANE_W.
  - MUL per lane: full unsigned 2*LANE_W product; lo = low half, hi = high half.
  - On the edge that completes step STEPS-1: regs[rd] <= lo and regs[(rd+1) mod NUM_REGS] <= hi. The index wraps, so rd = NUM_REGS-1 writes hi to reg 0. Then state returns to IDLE and done pulses.
  - Total: the accept edge plus STEPS EXEC cycles. The next command can be accepted STEPS+1 cycles after the previous accept.
- Reserved ops: accepted, no state change, err pulses the next cycle, no done pulse.
- cmd_rd/rs1/rs2 are only sampled at accept; inputs are ignored while cmd_ready=0.
- All lane arithmetic is unsigned.
- Lane i occupies bits [i*LANE_W +: LANE_W].

Decomposition:
- Package vec_pkg: op encodings (OP_WRITE, OP_READ, OP_ADD, OP_MUL), FSM state enum, and AW/VW/STEPS derived-width localparams.
- Sub-module vec_lane_alu: combinational, parametrised by LANE_W. Inputs a, b, op; outputs lo, hi. Instantiated LANES_PER_CYC times.

Test Plan (defaults, STEPS=4):
- Reset then READ r0..r3 -> rsp_data=0 each, rsp_valid exactly 1 cycle after accept, done pulses on handshake.
- WRITE r0 = all lanes 0xFFFFFFFF, WRITE r1 = all lanes 0x00000002, ADD rd=2 rs1=0 rs2=1 -> busy for 4 cycles; r2 lanes = 0x00000001, r3 lanes = 0x00000001; done pulses once.
- Same r0/r1, MUL rd=3 -> r3 lanes = 0xFFFFFFFE, r0 (wrap) lanes = 0x00000001; cmd_ready=0 for 4 cycles.
- READ r1 with rsp_ready held low 5 cycles -> rsp_data stable at 0x00000002 lanes and cmd_ready=0 throughout; cleared on the ready cycle.
- rst=0 at EXEC step 2 of an ADD -> all regs 0, no done pulse, IDLE next cycle.
- cmd_op=5 -> err pulses 1 cycle, registers unchanged, done stays 0.
